mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle controller for the tiny-CPU datapath. It replaces single-cycle decode with an FSM: FETCH, DECODE, EXEC, MEM, WB.
- Instruction fetch and data access share one memory port, using a req/ready handshake with bounded wait.
- Per-state control strobes drive the PC, IR, register file, ALU and data memory.
- A retired-instruction counter is provided.

Parameters:
ALU_OP_W, 4, width of alu_op; encodings from shared package.
STALL_TIMEOUT, 16, max cycles waiting on mem_ready before FAULT; 0 disables timeout.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
opcode  in  6  IR[31:26]; valid from DECODE onward.
funct  in  6  IR[5:0].
alu_zero  in  1  ALU zero flag, sampled in EXEC for branches.
mem_ready  in  1  memory completes current request this cycle.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  store request (qualifies mem_req).
iord  out  1  0: address = PC (fetch); 1: address = ALU result register.
mem_op  out  2  word/byte/half.
mem_ext  out  1  1 = sign-extend load.
ir_write  out  1  latch instruction.
pc_write  out  1  unconditional PC update.
pc_src  out  2  0: PC+4; 1: branch target; 2: imm26 jump; 3: rs.
reg_write  out  1  register file write.
reg_dst  out  2  0: rt; 1: rd; 2: $31.
reg_src  out  2  0: ALU result register; 1: memory data register; 2: PC (already +4).
alu_src_a  out  1  0: rs; 1: shamt.
alu_src_b  out  1  0: rt; 1: ext imm32.
alu_op  out  ALU_OP_W  ALU operation.
state  out  3  current state, for debug.
fault  out  1  sticky memory timeout.
retired  out  CNT_W  instructions completed since reset.

Behaviour:
- All outputs are Moore: decoded from the state register and instruction class. The class is latched on the DECODE→EXEC transition; J/JAL/JR/JALR complete in DECODE using live opcode/funct.
- Reset (rst=1 at edge): state=FETCH, class=NOP, wait counter=0, fault=0, retired=0. During the reset cycle all strobes (mem_req, ir_write, pc_write, reg_write, mem_we) are forced 0. rst mid-operation abandons the instruction with no partial write.
- FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE (1 cycle):
  - J: pc_write, pc_src=2, →FETCH.
  - JAL: also reg_write, reg_dst=2, reg_src=2.
  - JR: pc_src=3.
  - JALR: pc_src=3, reg_write, reg_dst=1, reg_src=2.
  - Otherwise →EXEC.
- EXEC (1 cycle): drive alu_op/alu_src_a/alu_src_b per class.
  - Branches: alu_op=SUB. pc_write=1 with pc_src=1 iff (BEQ and alu_zero) or (BNE and !alu_zero); →FETCH.
  - Loads/stores: →MEM.
  - ALU/imm ops: →WB.
- MEM: mem_req=1, iord=1, mem_we=store, mem_op/mem_ext per opcode. On mem_ready: store →FETCH; load →WB.
- WB (1 cycle): reg_write=1. reg_dst=0 for imm/load, 1 for R-type. reg_src=1 for load, else 0. →FETCH.
- Latency: jumps 2 cycles; branches 3; ALU 4; stores 4; loads 5 (each memory access counted with zero wait states).
- Timeout: the wait counter increments each cycle in FETCH/MEM while mem_ready=0 and clears on state exit. When it reaches STALL_TIMEOUT, go to FAULT. FAULT: all strobes 0, fault=1, held until rst.
- retired increments by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB. It wraps modulo 2^CNT_W.
- Unrecognised opcode/funct: treated as NOP (DECODE→FETCH, no writes, counted as retired) unless the optional feature is enabled.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an undecoded instruction in DECODE goes to TRAP. TRAP: strobes 0, extra output illegal=1, sticky until rst, not counted as retired.
- Undefined: the illegal port and TRAP state are absent; NOP behaviour applies.

Decomposition:
- Shared package: state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5, TRAP=6), instruction class enum, OPCODE_*/FUNCT_* constants, ALU_* and MEM_* encodings, pc_src codes.
- One sub-module: mc_decode, a combinational opcode/funct → class + alu_op/mem_op/mem_ext decoder. mc_ctrl holds the FSM, wait counter and retired counter.

Test Plan:
- ADD (opcode 0x00, funct 0x20), mem_ready tied 1 → states 0,1,2,4,0; reg_write=1 only in WB with reg_dst=1; retired 0→1.
- LW (0x23) with mem_ready low 3 cycles in MEM → MEM lasts 4 cycles; WB has reg_src=1, reg_dst=0; mem_ext=1.
- BEQ (0x04): alu_zero=1 → pc_write=1, pc_src=1 in EXEC. Repeat with alu_zero=0 → pc_write=0; both take 3 cycles.
- JAL (0x03) → DECODE asserts pc_write, pc_src=2, reg_write, reg_dst=2, reg_src=2; next state FETCH.
- STALL_TIMEOUT=4, mem_ready held 0 in FETCH → FAULT after 4 wait cycles, fault=1; rst → state=0, fault=0, retired=0.
- Opcode 0x3F with ILLEGAL_TRAP_EN → illegal=1, retired unchanged. Without the macro → returns to FETCH, retired+1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, instruction
// classes, opcode/funct constants, ALU/memory encodings and mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_RTYPE, CL_IMM, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE,
    CL_J, CL_JAL, CL_JR, CL_JALR, CL_ILLEGAL
  } instr_class_t;

  localparam int ALU_W    = 4;
  localparam int MEM_OP_W = 2;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALU_W-1:0] ALU_LUI  = 4'd11;

  localparam logic [MEM_OP_W-1:0] MEM_WORD = 2'd0;
  localparam logic [MEM_OP_W-1:0] MEM_BYTE = 2'd1;
  localparam logic [MEM_OP_W-1:0] MEM_HALF = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_MDR = 2'd1;
  localparam logic [1:0] RS_PC  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    instr_class_t          cls;
    logic [ALU_W-1:0]      alu_op;
    logic [MEM_OP_W-1:0]   mem_op;
    logic                  mem_ext;
    logic                  shamt;
  } dec_t;

  localparam dec_t DEC_NOP = '{cls: CL_NOP, alu_op: ALU_ADD, mem_op: MEM_WORD,
                               mem_ext: 1'b0, shamt: 1'b0};

  // Classes whose second ALU operand is the extended immediate.
  function automatic logic uses_imm(input instr_class_t c);
    return (c == CL_IMM) || (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Shared instruction/data memory port: req is held until ready completes it.
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  // mem_req stays high until mem_ready is seen with it; mem_we, iord, mem_op
  // and mem_ext qualify the request; mem_ready without mem_req is ignored.
  logic                mem_req;
  logic                mem_we;
  logic                mem_ready;
  logic                iord;
  logic [MEM_OP_W-1:0] mem_op;
  logic                mem_ext;

  modport master (output mem_req, mem_we, iord, mem_op, mem_ext, input mem_ready);
  modport slave  (input mem_req, mem_we, iord, mem_op, mem_ext, output mem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class plus ALU and memory
// operation; anything not listed decodes as CL_ILLEGAL.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CL_ILLEGAL, alu_op: ALU_ADD, mem_op: MEM_WORD, mem_ext: 1'b0, shamt: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        dec.cls = CL_RTYPE;
        case (funct)
          FN_SLL:            begin dec.alu_op = ALU_SLL; dec.shamt = 1'b1; end
          FN_SRL:            begin dec.alu_op = ALU_SRL; dec.shamt = 1'b1; end
          FN_SRA:            begin dec.alu_op = ALU_SRA; dec.shamt = 1'b1; end
          FN_JR:             dec.cls = CL_JR;
          FN_JALR:           dec.cls = CL_JALR;
          FN_ADD, FN_ADDU:   dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU:   dec.alu_op = ALU_SUB;
          FN_AND:            dec.alu_op = ALU_AND;
          FN_OR:             dec.alu_op = ALU_OR;
          FN_XOR:            dec.alu_op = ALU_XOR;
          FN_NOR:            dec.alu_op = ALU_NOR;
          FN_SLT:            dec.alu_op = ALU_SLT;
          FN_SLTU:           dec.alu_op = ALU_SLTU;
          default:           dec.cls = CL_ILLEGAL;
        endcase
      end
      OP_J:     dec.cls = CL_J;
      OP_JAL:   dec.cls = CL_JAL;
      OP_BEQ:   begin dec.cls = CL_BEQ; dec.alu_op = ALU_SUB; end
      OP_BNE:   begin dec.cls = CL_BNE; dec.alu_op = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin dec.cls = CL_IMM; dec.alu_op = ALU_ADD;  end
      OP_SLTI:  begin dec.cls = CL_IMM; dec.alu_op = ALU_SLT;  end
      OP_SLTIU: begin dec.cls = CL_IMM; dec.alu_op = ALU_SLTU; end
      OP_ANDI:  begin dec.cls = CL_IMM; dec.alu_op = ALU_AND;  end
      OP_ORI:   begin dec.cls = CL_IMM; dec.alu_op = ALU_OR;   end
      OP_XORI:  begin dec.cls = CL_IMM; dec.alu_op = ALU_XOR;  end
      OP_LUI:   begin dec.cls = CL_IMM; dec.alu_op = ALU_LUI;  end
      OP_LB:    begin dec.cls = CL_LOAD; dec.mem_op = MEM_BYTE; dec.mem_ext = 1'b1; end
      OP_LH:    begin dec.cls = CL_LOAD; dec.mem_op = MEM_HALF; dec.mem_ext = 1'b1; end
      OP_LW:    begin dec.cls = CL_LOAD; dec.mem_op = MEM_WORD; dec.mem_ext = 1'b1; end
      OP_LBU:   begin dec.cls = CL_LOAD; dec.mem_op = MEM_BYTE; end
      OP_LHU:   begin dec.cls = CL_LOAD; dec.mem_op = MEM_HALF; end
      OP_SB:    begin dec.cls = CL_STORE; dec.mem_op = MEM_BYTE; end
      OP_SH:    begin dec.cls = CL_STORE; dec.mem_op = MEM_HALF; end
      OP_SW:    begin dec.cls = CL_STORE; dec.mem_op = MEM_WORD; end
      default:  dec.cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM (FETCH/DECODE/EXEC/MEM/WB) with memory stall
// timeout and retired counter. Define ILLEGAL_TRAP_EN to trap undecoded ops.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W      = 4,
  parameter int STALL_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  mc_ctrl_if.master           bus,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                alu_zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          reg_src,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                fault,
`ifdef ILLEGAL_TRAP_EN
  output logic                illegal,
`endif
  output logic [CNT_W-1:0]    retired
);

  localparam int WAIT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

  state_t              state_q, state_d;
  dec_t                live, cur_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    retired_q;
  logic                timeout_hit, retire;
  logic                req_c, we_c, irw_c, pcw_c, rw_c;
  logic                iord_c, mem_ext_c;
  logic [MEM_OP_W-1:0] mem_op_c;
  logic [ALU_W-1:0]    alu_op_c;

  mc_decode u_decode (.opcode(opcode), .funct(funct), .dec(live));

  // The stalled cycle that would make the wait count reach the limit moves to FAULT.
  assign timeout_hit = (STALL_TIMEOUT != 0) && !bus.mem_ready &&
                       (wait_q == WAIT_W'(STALL_TIMEOUT - 1));

  assign retire = (state_d == ST_FETCH) &&
                  ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                   (state_q == ST_MEM)    || (state_q == ST_WB));

  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    we_c      = 1'b0;
    irw_c     = 1'b0;
    pcw_c     = 1'b0;
    rw_c      = 1'b0;
    iord_c    = 1'b0;
    mem_op_c  = MEM_WORD;
    mem_ext_c = 1'b0;
    pc_src    = PC_SEQ;
    reg_dst   = RD_RT;
    reg_src   = RS_ALU;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op_c  = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        req_c = 1'b1;
        if (bus.mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        // Jumps finish here from the live decode; everything else is latched.
        case (live.cls)
          CL_J:    begin pcw_c = 1'b1; pc_src = PC_JUMP; state_d = ST_FETCH; end
          CL_JAL:  begin
            pcw_c = 1'b1; pc_src = PC_JUMP;
            rw_c = 1'b1; reg_dst = RD_RA; reg_src = RS_PC;
            state_d = ST_FETCH;
          end
          CL_JR:   begin pcw_c = 1'b1; pc_src = PC_REG; state_d = ST_FETCH; end
          CL_JALR: begin
            pcw_c = 1'b1; pc_src = PC_REG;
            rw_c = 1'b1; reg_dst = RD_RD; reg_src = RS_PC;
            state_d = ST_FETCH;
          end
`ifdef ILLEGAL_TRAP_EN
          CL_ILLEGAL: state_d = ST_TRAP;
`else
          CL_ILLEGAL: state_d = ST_FETCH;
`endif
          CL_NOP:  state_d = ST_FETCH;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_op_c  = cur_q.alu_op;
        alu_src_a = cur_q.shamt;
        alu_src_b = uses_imm(cur_q.cls);
        case (cur_q.cls)
          CL_BEQ, CL_BNE: begin
            pc_src  = PC_BRANCH;
            pcw_c   = (cur_q.cls == CL_BEQ) ? alu_zero : !alu_zero;
            state_d = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        req_c     = 1'b1;
        iord_c    = 1'b1;
        we_c      = (cur_q.cls == CL_STORE);
        mem_op_c  = cur_q.mem_op;
        mem_ext_c = cur_q.mem_ext;
        if (bus.mem_ready) begin
          state_d = (cur_q.cls == CL_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rw_c    = 1'b1;
        reg_dst = (cur_q.cls == CL_RTYPE) ? RD_RD : RD_RT;
        reg_src = (cur_q.cls == CL_LOAD) ? RS_MDR : RS_ALU;
        state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:  state_d = ST_TRAP;
`endif
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cur_q     <= DEC_NOP;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE && state_d == ST_EXEC) cur_q <= live;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !bus.mem_ready) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Strobes are gated by rst so a reset cycle never commits a partial write.
  assign bus.mem_req = req_c & ~rst;
  assign bus.mem_we  = we_c  & ~rst;
  assign ir_write    = irw_c & ~rst;
  assign pc_write    = pcw_c & ~rst;
  assign reg_write   = rw_c  & ~rst;
  assign bus.iord    = iord_c;
  assign bus.mem_op  = mem_op_c;
  assign bus.mem_ext = mem_ext_c;
  assign alu_op      = ALU_OP_W'(alu_op_c);
  assign state       = state_q;
  assign fault       = (state_q == ST_FAULT);
`ifdef ILLEGAL_TRAP_EN
  assign illegal     = (state_q == ST_TRAP);
`endif
  assign retired     = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction state sequences and strobes,
// memory stalls, timeout fault, mid-instruction reset, illegal opcode.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        alu_zero = 1'b0;
  logic        ir_write, pc_write, reg_write, alu_src_a, alu_src_b, fault;
  logic [1:0]  pc_src, reg_dst, reg_src;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int total = 0;
  int bad = 0;
  int exp_ret = 0;
  logic [2:0] exp_q[$];

  mc_ctrl_if bus();

  mc_ctrl #(.ALU_OP_W(4), .STALL_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .reg_src(reg_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .fault(fault),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Checks state (next from exp_q) and {mem_req, mem_we, ir_write, pc_write, reg_write}.
  task automatic cyc(input logic [4:0] strb);
    logic [2:0] es;
    @(negedge clk);
    if (exp_q.size() != 0) es = exp_q.pop_front();
    else es = 3'd7;
    check_eq("state", 32'(state), 32'(es));
    check_eq("strobes", 32'({bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write}), 32'(strb));
  endtask

  task automatic push4(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    adv();
    adv();
    exp_q.push_back(3'd0);
    cyc(5'b00000);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    adv();
    rst = 1'b0;
    exp_ret = 0;
  endtask

  task automatic run_alu(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] ealu,
                         input logic ea, input logic eb, input logic [1:0] edst);
    opcode = op; funct = fn; bus.mem_ready = 1'b1;
    push4(3'd0, 3'd1, 3'd2, 3'd4);
    cyc(5'b10110);
    check_eq("fetch_iord", 32'(bus.iord), 32'd0);
    check_eq("fetch_pc_src", 32'(pc_src), 32'd0);
    check_eq("retired", retired, 32'(exp_ret));
    adv();
    cyc(5'b00000); adv();
    cyc(5'b00000);
    check_eq("alu_op", 32'(alu_op), 32'(ealu));
    check_eq("alu_src_a", 32'(alu_src_a), 32'(ea));
    check_eq("alu_src_b", 32'(alu_src_b), 32'(eb));
    adv();
    cyc(5'b00001);
    check_eq("wb_reg_dst", 32'(reg_dst), 32'(edst));
    check_eq("wb_reg_src", 32'(reg_src), 32'd0);
    adv();
    exp_ret++;
  endtask

  task automatic run_branch(input logic [5:0] op, input logic zero, input logic pcw);
    opcode = op; funct = 6'h00; alu_zero = zero; bus.mem_ready = 1'b1;
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    cyc(5'b10110);
    check_eq("retired", retired, 32'(exp_ret));
    adv();
    cyc(5'b00000); adv();
    cyc({3'b000, pcw, 1'b0});
    check_eq("br_alu_op", 32'(alu_op), 32'(ALU_SUB));
    if (pcw) check_eq("br_pc_src", 32'(pc_src), 32'd1);
    adv();
    exp_ret++;
  endtask

  task automatic run_jump(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] epc,
                          input logic rw, input logic [1:0] edst);
    opcode = op; funct = fn; bus.mem_ready = 1'b1;
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    cyc(5'b10110);
    check_eq("retired", retired, 32'(exp_ret));
    adv();
    cyc({3'b000, 1'b1, rw});
    check_eq("jmp_pc_src", 32'(pc_src), 32'(epc));
    if (rw) begin
      check_eq("jmp_reg_dst", 32'(reg_dst), 32'(edst));
      check_eq("jmp_reg_src", 32'(reg_src), 32'd2);
    end
    adv();
    exp_ret++;
  endtask

  initial begin
    bus.mem_ready = 1'b1;
    do_reset();

    run_alu(6'h00, 6'h20, ALU_ADD, 1'b0, 1'b0, 2'd1);
    run_alu(6'h0D, 6'h00, ALU_OR,  1'b0, 1'b1, 2'd0);
    run_alu(6'h00, 6'h03, ALU_SRA, 1'b1, 1'b0, 2'd1);

    // LW with three stalled MEM cycles (one short of the timeout)
    opcode = 6'h23; funct = 6'h00; bus.mem_ready = 1'b1;
    push4(3'd0, 3'd1, 3'd2, 3'd3);
    push4(3'd3, 3'd3, 3'd3, 3'd4);
    cyc(5'b10110); adv();
    bus.mem_ready = 1'b0;
    cyc(5'b00000); adv();
    cyc(5'b00000);
    check_eq("lw_alu_src_b", 32'(alu_src_b), 32'd1);
    check_eq("lw_alu_op", 32'(alu_op), 32'(ALU_ADD));
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(5'b10000);
      check_eq("lw_iord", 32'(bus.iord), 32'd1);
      check_eq("lw_mem_ext", 32'(bus.mem_ext), 32'd1);
      check_eq("lw_mem_op", 32'(bus.mem_op), 32'(MEM_WORD));
      adv();
    end
    bus.mem_ready = 1'b1;
    cyc(5'b10000); adv();
    cyc(5'b00001);
    check_eq("lw_reg_src", 32'(reg_src), 32'd1);
    check_eq("lw_reg_dst", 32'(reg_dst), 32'd0);
    check_eq("lw_fault", 32'(fault), 32'd0);
    adv();
    exp_ret++;

    // SB: four cycles, mem_we only in MEM
    opcode = 6'h28;
    push4(3'd0, 3'd1, 3'd2, 3'd3);
    cyc(5'b10110);
    check_eq("retired", retired, 32'(exp_ret));
    adv();
    cyc(5'b00000); adv();
    cyc(5'b00000); adv();
    cyc(5'b11000);
    check_eq("sb_mem_op", 32'(bus.mem_op), 32'(MEM_BYTE));
    check_eq("sb_mem_ext", 32'(bus.mem_ext), 32'd0);
    adv();
    exp_ret++;

    run_branch(6'h04, 1'b1, 1'b1);
    run_branch(6'h04, 1'b0, 1'b0);
    run_branch(6'h05, 1'b0, 1'b1);
    run_branch(6'h05, 1'b1, 1'b0);

    run_jump(6'h02, 6'h00, 2'd2, 1'b0, 2'd0);
    run_jump(6'h03, 6'h00, 2'd2, 1'b1, 2'd2);
    run_jump(6'h00, 6'h08, 2'd3, 1'b0, 2'd0);
    run_jump(6'h00, 6'h09, 2'd3, 1'b1, 2'd1);

    // Undecoded opcode 0x3F
    opcode = 6'h3F; funct = 6'h00; bus.mem_ready = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    push4(3'd0, 3'd1, 3'd6, 3'd6);
    cyc(5'b10110); adv();
    cyc(5'b00000); adv();
    cyc(5'b00000);
    check_eq("illegal", 32'(illegal), 32'd1);
    adv();
    cyc(5'b00000);
    check_eq("illegal_sticky", 32'(illegal), 32'd1);
    check_eq("illegal_retired", retired, 32'(exp_ret));
`else
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    cyc(5'b10110); adv();
    cyc(5'b00000); adv();
    exp_ret++;
    cyc(5'b10110);
    check_eq("nop_retired", retired, 32'(exp_ret));
`endif
    do_reset();

    // Reset abandons an ADD in WB, then FETCH stalls into FAULT
    run_jump(6'h02, 6'h00, 2'd2, 1'b0, 2'd0);
    opcode = 6'h00; funct = 6'h20; bus.mem_ready = 1'b1;
    push4(3'd0, 3'd1, 3'd2, 3'd4);
    cyc(5'b10110); adv();
    cyc(5'b00000); adv();
    cyc(5'b00000);
    check_eq("pre_rst_retired", retired, 32'd1);
    adv();
    rst = 1'b1;
    cyc(5'b00000);
    adv();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    push4(3'd0, 3'd0, 3'd0, 3'd0);
    exp_q.push_back(3'd5); exp_q.push_back(3'd5);
    cyc(5'b10000);
    check_eq("post_rst_retired", retired, 32'd0);
    check_eq("post_rst_fault", 32'(fault), 32'd0);
    adv();
    cyc(5'b10000); adv();
    cyc(5'b10000); adv();
    cyc(5'b10000);
    check_eq("pre_timeout_fault", 32'(fault), 32'd0);
    adv();
    cyc(5'b00000);
    check_eq("timeout_fault", 32'(fault), 32'd1);
    adv();
    bus.mem_ready = 1'b1;
    cyc(5'b00000);
    check_eq("fault_sticky", 32'(fault), 32'd1);
    check_eq("fault_retired", retired, 32'd0);
    adv();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
